// File: rtl/encrypt_sched.sv
// encrypt_sched: two-port round-robin front end for a single encryption6b core.
// A granted byte is loaded into the core for LOAD_CYC cycles. The scheduler then
// waits for ready, or for the watchdog to expire, and returns the result with a
// one-cycle ack to the port that won arbitration.
//
//   state | meaning
//   IDLE  | no transaction; sample req0/req1 and arbitrate
//   LOAD  | core_load held high, cnt counts down the load window
//   WAIT  | waiting for core_ready, cnt counts up toward the watchdog limit
//   DONE  | ack pulse to owner, result valid, fairness pointer updated
module encrypt_sched #(
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] dout,
  output logic [5:0] key_out,
  output logic       err,
  output logic       busy,
  output logic       owner,
  output logic       core_load,
  output logic [7:0] core_datain,
  input  logic       core_ready,
  input  logic [7:0] core_dataout,
  input  logic [5:0] core_key
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LOAD_LAST = 8'(LOAD_CYC - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       last, last_nx;
  logic       grant, sel;
  logic       tmo;

  logic       owner_nx;
  logic [7:0] datain_nx;
  logic [7:0] dout_nx;
  logic [5:0] key_nx;
  logic       err_nx;
  logic       ack0_nx, ack1_nx;
  logic       load_nx, busy_nx;

  // Arbitration: a lone requester wins; on a tie the port that was not served last wins
  always_comb begin
    grant = req0 | req1;
    sel   = (req0 & req1) ? ~last : req1;
    tmo   = (cnt == WAIT_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; core_ready only matters while waiting
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant) state_nx = LOAD;
      LOAD: if (cnt == 8'd0) state_nx = WAIT;
      WAIT: if (core_ready || tmo) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the counter, fairness pointer and every registered output
  always_comb begin
    cnt_nx    = cnt;
    last_nx   = last;
    owner_nx  = owner;
    datain_nx = core_datain;
    dout_nx   = dout;
    key_nx    = key_out;
    err_nx    = err;
    case (state)
      IDLE: begin
        if (grant) begin
          owner_nx  = sel;
          datain_nx = sel ? din1 : din0;
          cnt_nx    = LOAD_LAST;
        end
      end
      LOAD: begin
        cnt_nx = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
      end
      WAIT: begin
        cnt_nx = cnt + 8'd1;
        if (core_ready) begin
          dout_nx = core_dataout;
          key_nx  = core_key;
          err_nx  = 1'b0;
        end else if (tmo) begin
          dout_nx = 8'd0;
          key_nx  = 6'd0;
          err_nx  = 1'b1;
        end
      end
      DONE: begin
        last_nx = owner;
      end
      default: begin
        cnt_nx = 8'd0;
      end
    endcase
    // ack is set on the edge that enters DONE so it is high for the DONE cycle only
    ack0_nx = (state == WAIT) && (state_nx == DONE) && !owner;
    ack1_nx = (state == WAIT) && (state_nx == DONE) &&  owner;
    load_nx = (state_nx == LOAD);
    busy_nx = (state_nx != IDLE);
  end

  // Registered datapath and outputs; reset clears them without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 8'd0;
      last        <= 1'b1;
      owner       <= 1'b0;
      core_datain <= 8'd0;
      dout        <= 8'd0;
      key_out     <= 6'd0;
      err         <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      core_load   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      last        <= last_nx;
      owner       <= owner_nx;
      core_datain <= datain_nx;
      dout        <= dout_nx;
      key_out     <= key_nx;
      err         <= err_nx;
      ack0        <= ack0_nx;
      ack1        <= ack1_nx;
      core_load   <= load_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_encrypt_sched.sv
// Self-checking bench for encrypt_sched. Expected timing comes from the
// cycle formulas (grant + LOAD_CYC + 2 + w, grant + LOAD_CYC + 1 + TIMEOUT),
// and the expected winner from a round-robin pointer kept by the bench.
module tb_encrypt_sched;

  localparam int LC = 2;
  localparam int TO = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] din0, din1;
  logic       ack0, ack1;
  logic [7:0] dout;
  logic [5:0] key_out;
  logic       err, busy, owner, core_load;
  logic [7:0] core_datain;
  logic       core_ready;
  logic [7:0] core_dataout;
  logic [5:0] core_key;

  int n_checks = 0;
  int n_pass   = 0;
  bit m_last   = 1'b1;

  encrypt_sched #(.LOAD_CYC(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .ack0(ack0), .ack1(ack1), .dout(dout), .key_out(key_out),
    .err(err), .busy(busy), .owner(owner),
    .core_load(core_load), .core_datain(core_datain),
    .core_ready(core_ready), .core_dataout(core_dataout), .core_key(core_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One transaction, started in an IDLE cycle just before the grant edge.
  // w = WAIT cycle in which the core raises ready (-1: never).
  task automatic txn(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1,
                     input int w, input logic [7:0] cdo, input logic [5:0] ck,
                     input bit stale, input bit hold, input bit withdraw, input bit late_other);
    bit win;
    bit ok;
    int ack_at;
    int c;
    req0 = r0; req1 = r1; din0 = d0; din1 = d1;
    core_ready = stale; core_dataout = cdo; core_key = ck;
    win    = (r0 && r1) ? ~m_last : r1;
    ok     = (w >= 0) && (w < TO);
    ack_at = ok ? LC + 2 + w : LC + 1 + TO;
    @(posedge clk); #1;
    c = 1;
    while (c <= ack_at + 1) begin
      chk("busy", busy, c <= ack_at);
      chk("core_load", core_load, c <= LC);
      chk("ack0", ack0, (c == ack_at) && !win);
      chk("ack1", ack1, (c == ack_at) && win);
      if (c <= ack_at) chk("owner", owner, win);
      if (c == 1) chk("core_datain", core_datain, win ? d1 : d0);
      if (c == ack_at) begin
        chk("dout", dout, ok ? cdo : 8'd0);
        chk("key_out", key_out, ok ? ck : 6'd0);
        chk("err", err, !ok);
      end
      core_ready = ((w >= 0) && (c == LC + 1 + w)) || (stale && (c <= LC));
      if (c == 1 && withdraw) begin
        if (win) req1 = 1'b0; else req0 = 1'b0;
      end
      if (c == 1 && late_other) begin
        if (win) req0 = 1'b1; else req1 = 1'b1;
      end
      if (c == ack_at && !hold) begin
        if (win) req1 = 1'b0; else req0 = 1'b0;
      end
      if (c <= ack_at) begin
        @(posedge clk); #1;
      end
      c++;
    end
    m_last = win;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = 8'd0; din1 = 8'd0;
    core_ready = 1'b0; core_dataout = 8'd0; core_key = 6'd0;
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_dout", dout, 0);
    chk("rst_key", key_out, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_load", core_load, 0);
    chk("rst_datain", core_datain, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single request on port 0, ready three cycles into WAIT
    txn(1, 0, 8'h41, 8'h00, 3, 8'h5A, 6'h2C, 0, 0, 0, 0);

    // tie after reset, both held: 0,1,0,1
    m_last = 1'b1;
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      txn(1, 1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
          8'($urandom), 6'($urandom), 0, 1, 0, 0);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // watchdog expiry, then a normal transaction
    txn(0, 1, 8'h00, 8'h77, -1, 8'hEE, 6'h3F, 0, 0, 0, 0);
    txn(1, 0, 8'h12, 8'h00, 1, 8'hC3, 6'h15, 0, 0, 0, 0);

    // reset in WAIT: busy and load drop at once, no ack
    req0 = 1'b1; din0 = 8'h99; core_ready = 1'b0;
    @(posedge clk); #1;
    repeat (LC + 1) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1; #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_load", core_load, 0);
    @(posedge clk); #1;
    chk("rstw_ack0", ack0, 0);
    chk("rstw_ack1", ack1, 0);
    @(negedge clk); rst = 1'b0; m_last = 1'b1;
    txn(1, 0, 8'h99, 8'h00, 0, 8'h3C, 6'h0A, 0, 0, 0, 0);

    // reset in LOAD: core_load falls without a clock edge
    req1 = 1'b1; din1 = 8'h5F;
    @(posedge clk); #3;
    chk("pre_rstl_load", core_load, 1);
    rst = 1'b1; #1;
    chk("rstl_load", core_load, 0);
    chk("rstl_busy", busy, 0);
    @(negedge clk); rst = 1'b0; m_last = 1'b1; req1 = 1'b0;
    @(posedge clk); #1;

    // port 1 withdraws during LOAD while port 0 becomes pending
    txn(0, 1, 8'hA0, 8'hB1, 2, 8'h6D, 6'h21, 0, 0, 1, 1);
    txn(1, 0, 8'hA0, 8'h00, 0, 8'h44, 6'h05, 0, 0, 0, 0);

    // ready held through IDLE and LOAD: ack at minimum latency
    txn(1, 0, 8'h3E, 8'h00, 0, 8'h81, 6'h19, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int rr;
      int t;
      rr = int'($urandom_range(1, 3));
      t  = int'($urandom_range(0, TO + 2));
      txn(rr[0], rr[1], 8'($urandom), 8'($urandom), (t > TO) ? -1 : t,
          8'($urandom), 6'($urandom), 1'($urandom), 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encrypt_sched.md
# encrypt_sched

Two-port round-robin scheduler that shares one `encryption6b` stream-encryption core between two requesters. It accepts byte requests, drives the core's `load`/`datain` sequence, and waits for `ready`. It then captures `dataout` and `key` and returns them to the winning requester with a one-cycle acknowledge. A watchdog bounds the wait so a stuck core cannot hang either requester.

## Interface
- `LOAD_CYC`, 2: number of cycles `core_load` is held high per transaction (1..15).
- `TIMEOUT`, 63: maximum WAIT-state cycles before aborting with error (1..255).
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1 each  request from port 0 / port 1; level, held until own ack.
- `din0`, `din1`  in  8 each  plaintext byte for port 0 / port 1; stable while req high.
- `ack0`, `ack1`  out  1 each  one-cycle completion pulse to port 0 / port 1.
- `dout`  out  8  encrypted byte; valid only while ack0 or ack1 is high.
- `key_out`  out  6  core key captured with `dout`.
- `err`  out  1  high with ack when the transaction timed out.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  port currently served; valid while busy.
- `core_load`  out  1  to core `load`.
- `core_datain`  out  8  to core `datain`; latched copy of the winner's din.
- `core_ready`  in  1  from core `ready`.
- `core_dataout`  in  8  from core `dataout`.
- `core_key`  in  6  from core `key`.

## Operation
- States: IDLE, LOAD, WAIT, DONE. 2-bit state register; all outputs registered.
- IDLE:
  - No req: stay.
  - One req: grant that port.
  - Both: grant the port ≠ `last`. `last` resets to 1, so port 0 wins the first tie.
  - On grant: latch din into `core_datain`, set `owner`, load cnt=LOAD_CYC-1, go LOAD.
- LOAD: `core_load`=1. Decrement cnt. When cnt==0, go WAIT with cnt cleared.
- WAIT:
  - `core_load`=0; cnt increments each cycle.
  - `core_ready`=1: capture `core_dataout`→`dout` and `core_key`→`key_out`, err=0, go DONE.
  - Else if cnt==TIMEOUT-1: dout=0, key_out=0, err=1, go DONE.
  - `core_ready` is ignored in all other states.
- DONE:
  - `ack[owner]`=1 for exactly this cycle; `last`←`owner`; go IDLE.
  - dout/key_out/err are held until the next DONE; they are meaningful only with ack.
- Requests are sampled only in IDLE. A req change while busy has no effect on the current transaction.
- A port whose req drops before its ack still gets its ack pulse. The requester ignores it.
- A requester that keeps req high after ack is re-arbitrated in the next IDLE cycle, so fairness alternates when both are pending.
- cnt is 8 bits wide; no wrap is possible because TIMEOUT ≤ 255.

## Timing
- Reset (async, immediate):
  - state=IDLE, `last`=1, cnt=0.
  - All outputs 0: ack0, ack1, dout, key_out, err, busy, owner, core_load, core_datain.
- Reset mid-transaction: `core_load` and `busy` drop without a clock edge. No ack is issued and the transaction is lost.
- Grant edge = edge at which IDLE samples req (cycle G).
  - `core_load` is high in cycles G+1..G+LOAD_CYC.
  - First WAIT cycle is G+LOAD_CYC+1.
  - If ready is seen in WAIT cycle w (w=0 first), ack is high in cycle G+LOAD_CYC+2+w.
- Minimum req-to-ack latency = LOAD_CYC+2 cycles (4 at defaults).
- Timeout: ack with err=1 in cycle G+LOAD_CYC+1+TIMEOUT.
- Back-to-back: after the DONE cycle there is one IDLE cycle, then the next grant. Period per transaction = LOAD_CYC+3+w cycles.

## Test plan
- Single request:
  - Stimulus: req0=1, din0=8'h41, core model raises ready 3 cycles into WAIT with dataout=8'h5A, key=6'h2C.
  - Response: core_load high 2 cycles, core_datain=8'h41. ack0 high exactly one cycle 7 cycles after grant, with dout=8'h5A, key_out=6'h2C, err=0. ack1 stays 0.
- Tie after reset:
  - Stimulus: req0 and req1 asserted together, both held.
  - Response: serviced in order port0, port1, port0, port1. owner alternates and each ack is one cycle.
- Timeout:
  - Stimulus: TIMEOUT=5, core ready never rises.
  - Response: ack to owner with err=1, dout=0, 8 cycles after grant. Next request then completes normally with err=0.
- Reset mid-WAIT:
  - Stimulus: assert rst between clock edges during WAIT.
  - Response: busy=0 and core_load=0 immediately, no ack. After release, a new req0 completes normally.
- Withdrawn request:
  - Stimulus: req1 granted, req1 dropped during LOAD.
  - Response: ack1 still pulses once. Then a pending req0 is granted in the following IDLE cycle.
- Stale ready:
  - Stimulus: core_ready held high during IDLE and LOAD.
  - Response: no capture before WAIT. ack arrives at the minimum latency of 4 cycles.
